// File: rtl/seq_det_pkg.sv
// Shared defaults and encodings for the sequence detector and its match logger.
package seq_det_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Saturation ceiling of the match counter at its default width.
    localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        DET_IDLE    = 2'd0,
        DET_PARTIAL = 2'd1,
        DET_HIT     = 2'd2
    } det_state_t;

endpackage

// File: rtl/match_ts_fifo.sv
// Show-ahead synchronous FIFO holding match timestamps; no write-to-read bypass.
module match_ts_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign head = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector match pulses into a FIFO and keeps a saturating match count.
module seq_match_logger
    import seq_det_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             match,
    input  logic             en,
    input  logic             clr,
    output logic             ts_valid,
    input  logic             ts_ready,
    output logic [TS_W-1:0]  ts_data,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  tsc_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TS_W-1:0]  fifo_head;

    assign accept = match && en && !clr;
    // A pop coinciding with clr is discarded along with the rest of the log.
    assign pop    = ts_valid && ts_ready && !clr;

    always_ff @(posedge clk) begin
        if (rst) tsc_reg <= '0;
        else     tsc_reg <= tsc_reg + TS_W'(1);
    end

    match_ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (accept),
        .din   (tsc_reg),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (clr) begin
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (accept) begin
            if (count_reg != CNT_MAX) count_next = count_reg + CNT_W'(1);
            // Full with a simultaneous pop frees a slot, so nothing is lost.
            if (fifo_full && !pop) overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign ts_valid    = !fifo_empty;
    assign ts_data     = ts_valid ? fifo_head : '0;
    assign match_count = count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger: default instance plus a narrow TS_W=4/CNT_W=3 instance.
module tb_seq_match_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        match, en, clr, ts_ready;
    logic        ts_valid, overflow;
    logic [15:0] ts_data;
    logic [7:0]  match_count;

    logic        match2, en2, clr2, ts_ready2;
    logic        ts_valid2, overflow2;
    logic [3:0]  ts_data2;
    logic [2:0]  match_count2;

    int checks = 0;
    int errors = 0;
    int tsc_cur = 0;

    always #5 clk = ~clk;

    seq_match_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .match(match), .en(en), .clr(clr),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
        .match_count(match_count), .overflow(overflow)
    );

    seq_match_logger #(.TS_W(4), .DEPTH(4), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .match(match2), .en(en2), .clr(clr2),
        .ts_valid(ts_valid2), .ts_ready(ts_ready2), .ts_data(ts_data2),
        .match_count(match_count2), .overflow(overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; tsc_cur mirrors the timestamp counter of the cycle now in progress.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        tsc_cur = r ? 0 : tsc_cur + 1;
    endtask

    task automatic tick_until(input int t);
        while (tsc_cur != t) tick();
    endtask

    initial begin
        rst = 1'b1; match = 1'b0; en = 1'b1; clr = 1'b0; ts_ready = 1'b0;
        match2 = 1'b0; en2 = 1'b1; clr2 = 1'b0; ts_ready2 = 1'b0;
        tick();
        tick();
        chk("rst_valid", ts_valid, 0);
        chk("rst_data", ts_data, 0);
        chk("rst_count", match_count, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        $display("step reset done");

        // Ready while empty is harmless.
        tick_until(2);
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        chk("ready_empty_valid", ts_valid, 0);

        // Single match at tsc=5, visible one cycle later.
        tick_until(5);
        match = 1'b1;
        #1;
        chk("no_bypass_valid", ts_valid, 0);
        tick();
        match = 1'b0;
        chk("single_valid", ts_valid, 1);
        chk("single_data", ts_data, 5);
        chk("single_count", match_count, 1);
        chk("single_ovf", overflow, 0);
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        chk("single_popped_valid", ts_valid, 0);
        chk("single_popped_data", ts_data, 0);
        $display("step single match tsc=%0d", tsc_cur);

        // Overflow: matches at 10..14 with the consumer stalled.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", match_count, 0);
        tick_until(10);
        match = 1'b1;
        for (int t = 10; t <= 14; t++) begin
            if (t == 14) chk("ovf_before", overflow, 0);
            tick();
        end
        match = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", match_count, 5);
        ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop_valid", ts_valid, 1);
            chk("ovf_pop_data", ts_data, 32'(10 + i));
            tick();
        end
        ts_ready = 1'b0;
        chk("ovf_drained_valid", ts_valid, 0);
        chk("ovf_sticky", overflow, 1);
        $display("step overflow tsc=%0d", tsc_cur);

        // Full FIFO with simultaneous push and pop.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", overflow, 0);
        match = 1'b1;
        tick_until(24);
        match = 1'b0;
        tick_until(30);
        match = 1'b1;
        ts_ready = 1'b1;
        chk("full_head", ts_data, 20);
        tick();
        match = 1'b0;
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_count", match_count, 5);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_ts;
            exp_ts = (i == 3) ? 32'd30 : 32'(21 + i);
            chk("full_pp_data", ts_data, exp_ts);
            tick();
        end
        ts_ready = 1'b0;
        chk("full_pp_empty", ts_valid, 0);
        $display("step full push+pop tsc=%0d", tsc_cur);

        // clr with match and pop in the same cycle, then en=0.
        match = 1'b1;
        tick_until(40);
        match = 1'b0;
        chk("pre_clr_ovf", overflow, 1);
        chk("pre_clr_count", match_count, 10);
        clr = 1'b1; match = 1'b1; ts_ready = 1'b1;
        tick();
        clr = 1'b0; match = 1'b0; ts_ready = 1'b0;
        chk("clr_valid", ts_valid, 0);
        chk("clr_data", ts_data, 0);
        chk("clr_count0", match_count, 0);
        chk("clr_ovf0", overflow, 0);
        en = 1'b0; match = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        match = 1'b0; en = 1'b1;
        chk("en0_valid", ts_valid, 0);
        chk("en0_count", match_count, 0);
        $display("step clr/en tsc=%0d", tsc_cur);

        // Reset with two entries queued.
        match = 1'b1;
        tick();
        tick();
        match = 1'b0;
        chk("pre_rst_valid", ts_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", ts_valid, 0);
        chk("mid_rst_data", ts_data, 0);
        chk("mid_rst_count", match_count, 0);
        match = 1'b1;
        tick();
        match = 1'b0;
        chk("tsc_restart_data", ts_data, 0);
        chk("tsc_restart_count", match_count, 1);
        $display("step mid-stream reset tsc=%0d", tsc_cur);

        // Narrow instance: timestamp wrap and count saturation.
        tick_until(15);
        match2 = 1'b1;
        tick();
        match2 = 1'b0;
        chk("wrap_first", ts_data2, 15);
        tick_until(17);
        match2 = 1'b1;
        tick();
        match2 = 1'b0;
        ts_ready2 = 1'b1;
        chk("wrap_head", ts_data2, 15);
        tick();
        chk("wrap_second", ts_data2, 1);
        tick();
        ts_ready2 = 1'b0;
        chk("wrap_empty", ts_valid2, 0);
        chk("sat_count2", match_count2, 2);
        match2 = 1'b1; ts_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_count7", match_count2, 7);
        tick();
        tick();
        match2 = 1'b0; ts_ready2 = 1'b0;
        chk("sat_hold", match_count2, 7);
        $display("step wrap/saturation tsc=%0d", tsc_cur);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_match_logger.md
SEQ_MATCH_LOGGER -- requirements
Module: seq_match_logger

Interface
REQ-001 Parameter TS_W, default 16, timestamp width in bits.
REQ-002 Parameter DEPTH, default 4, timestamp FIFO depth; must be a power of 2 and at least 2.
REQ-003 Parameter CNT_W, default 8, match counter width in bits.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 match  input  1  detector output pulse, sampled every clk; each high cycle counts as one match.
REQ-007 en  input  1  logging enable.
REQ-008 clr  input  1  synchronous clear of the log.
REQ-009 ts_valid  output  1  FIFO head is available.
REQ-010 ts_ready  input  1  consumer accepts the head.
REQ-011 ts_data  output  TS_W  timestamp at the FIFO head.
REQ-012 match_count  output  CNT_W  saturating count of accepted matches.
REQ-013 overflow  output  1  sticky flag: at least one timestamp was dropped.

Function
REQ-014 Free-running counter tsc: 0 in the first cycle after rst deasserts, +1 every cycle, wraps modulo 2^TS_W; en and clr do not affect it.
REQ-015 Accepted match: match=1, en=1, clr=0 in the same cycle.
REQ-016 Each accepted match pushes that cycle's tsc value (pre-increment) into the FIFO.
REQ-017 Each accepted match increments match_count by 1; the count saturates at 2^CNT_W-1 and never wraps.
REQ-018 FIFO is show-ahead. ts_valid = not empty. ts_data = head entry when ts_valid=1, else 0.
REQ-019 Pop occurs when ts_valid=1 and ts_ready=1 in the same cycle. ts_ready while empty has no effect.
REQ-020 Push-to-visible latency is 1 cycle; there is no same-cycle bypass, even when the FIFO is empty.
REQ-021 Push and pop in the same cycle both execute, including when full; occupancy is unchanged and nothing is dropped.
REQ-022 Push while full with no pop: entry is dropped, overflow is set the next cycle, match_count still increments.
REQ-023 Entries pop in strict push order; read/write pointers wrap modulo DEPTH.
REQ-024 clr=1 empties the FIFO and clears match_count and overflow next cycle. A match in that cycle is ignored. A pop in that cycle is discarded.
REQ-025 en=0 ignores matches; pops continue normally.
REQ-026 overflow stays set until clr or rst.

Reset
REQ-027 On a rising clk with rst=1: tsc=0, FIFO empty, ts_valid=0, ts_data=0, match_count=0, overflow=0.
REQ-028 rst has priority over clr, match and pop. Reset mid-stream discards all entries with no partial output.

Structure
REQ-029 Package seq_det_pkg holds the TS_W, DEPTH and CNT_W defaults and the saturating-increment constant (all-ones of CNT_W). The existing detector state encodings move to this package.
REQ-030 Storage and pointers are a single sub-module, match_ts_fifo (sync FIFO: push, pop, full, empty, head). Counters, accept logic and overflow live in the top.

Verification
REQ-031 Single match: rst released, match=1 at tsc=5, ts_ready=0 -> ts_valid=1 from tsc=6, ts_data=5, match_count=1, overflow=0.
REQ-032 Overflow: matches at tsc=10..14, ts_ready=0 -> FIFO holds 10,11,12,13; overflow=1 from tsc=15; match_count=5. Then ts_ready=1 -> pops 10,11,12,13 on consecutive cycles, then ts_valid=0.
REQ-033 Full with simultaneous push and pop: FIFO full [20..23], match at tsc=30 with ts_ready=1 -> pops 20, FIFO [21,22,23,30], overflow stays 0.
REQ-034 Wrap and saturation: TS_W=4, CNT_W=3; matches at tsc=15 and 17 give entries 15 then 1; 9 accepted matches give match_count=7.
REQ-035 clr and en: full FIFO with overflow=1; clr=1 together with match=1 -> next cycle ts_valid=0, match_count=0, overflow=0. Then en=0 with 3 matches -> no pushes, count stays 0.
REQ-036 Reset mid-stream: rst=1 for 1 cycle with 2 entries queued -> ts_valid=0, ts_data=0, tsc restarts at 0.
